// File: rtl/game_fsm.sv
// Chess-clock game sequencer: debounces the four board buttons, then steps
// IDLE / RUN_P1 / RUN_P2 / PAUSED / OVER and drives the timer-select outputs.
module game_fsm #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic       timeout1,
  input  logic       timeout2,
  output logic       enable,
  output logic [1:0] player,
  output logic       paused,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int NB        = 4;
  localparam int BTN_START = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_P1    = 2;
  localparam int BTN_P2    = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0] raw;
  logic [NB-1:0] press;

  assign raw = {btn_p2, btn_p1, btn_pause, btn_start};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             deb_reg;
      logic             deb_prev_reg;
      logic             press_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          deb_reg      <= 1'b0;
          deb_prev_reg <= 1'b0;
          press_reg    <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          // The counter only runs while the synchronized level disagrees with
          // the accepted level, so any bounce back restarts the window.
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            deb_reg <= sync2_reg;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
          deb_prev_reg <= deb_reg;
          press_reg    <= deb_reg & ~deb_prev_reg;
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    RUN_P1,
    RUN_P2,
    PAUSED,
    OVER
  } state_t;

  state_t     state_reg, state_next;
  logic       resume_p2_reg, resume_p2_next;
  logic [1:0] winner_reg, winner_next;
  logic       enable_reg, enable_next;
  logic [1:0] player_reg, player_next;
  logic       paused_reg, paused_next;
  logic       game_over_reg, game_over_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      resume_p2_reg <= 1'b0;
      winner_reg    <= 2'b00;
      enable_reg    <= 1'b0;
      player_reg    <= 2'b00;
      paused_reg    <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      resume_p2_reg <= resume_p2_next;
      winner_reg    <= winner_next;
      enable_reg    <= enable_next;
      player_reg    <= player_next;
      paused_reg    <= paused_next;
      game_over_reg <= game_over_next;
    end
  end

  // Timeout beats pause, pause beats the turn button.
  always_comb begin
    state_next     = state_reg;
    resume_p2_next = resume_p2_reg;
    winner_next    = winner_reg;
    case (state_reg)
      IDLE: begin
        if (press[BTN_START]) state_next = RUN_P1;
      end
      RUN_P1: begin
        if (timeout1) begin
          state_next  = OVER;
          winner_next = 2'b10;
        end else if (press[BTN_PAUSE]) begin
          state_next     = PAUSED;
          resume_p2_next = 1'b0;
        end else if (press[BTN_P1]) begin
          state_next = RUN_P2;
        end
      end
      RUN_P2: begin
        if (timeout2) begin
          state_next  = OVER;
          winner_next = 2'b01;
        end else if (press[BTN_PAUSE]) begin
          state_next     = PAUSED;
          resume_p2_next = 1'b1;
        end else if (press[BTN_P2]) begin
          state_next = RUN_P1;
        end
      end
      PAUSED: begin
        if (press[BTN_PAUSE]) state_next = resume_p2_reg ? RUN_P2 : RUN_P1;
      end
      OVER: begin
        if (press[BTN_START]) begin
          state_next  = IDLE;
          winner_next = 2'b00;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoding the next state keeps the registered outputs in step with the state.
  always_comb begin
    enable_next    = 1'b0;
    player_next    = 2'b00;
    paused_next    = 1'b0;
    game_over_next = 1'b0;
    case (state_next)
      RUN_P1: begin
        enable_next = 1'b1;
        player_next = 2'b01;
      end
      RUN_P2: begin
        enable_next = 1'b1;
        player_next = 2'b10;
      end
      PAUSED: begin
        paused_next = 1'b1;
        player_next = resume_p2_next ? 2'b10 : 2'b01;
      end
      OVER: game_over_next = 1'b1;
      default: ;
    endcase
  end

  assign enable    = enable_reg;
  assign player    = player_reg;
  assign paused    = paused_reg;
  assign game_over = game_over_reg;
  assign winner    = winner_reg;

endmodule

// File: tb/tb_game_fsm.sv
// Scoreboard bench for game_fsm: stimulus queues expected output changes with
// the clock edge they must appear on; a monitor compares every output change.
module tb_game_fsm;

  localparam int DEB       = 4;
  localparam int LAT       = DEB + 4;
  localparam int BTN_START = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_P1    = 2;
  localparam int BTN_P2    = 3;

  // {enable, player, paused, game_over, winner}
  localparam logic [6:0] O_IDLE    = 7'b0_00_0_0_00;
  localparam logic [6:0] O_P1      = 7'b1_01_0_0_00;
  localparam logic [6:0] O_P2      = 7'b1_10_0_0_00;
  localparam logic [6:0] O_PAUSE1  = 7'b0_01_1_0_00;
  localparam logic [6:0] O_PAUSE2  = 7'b0_10_1_0_00;
  localparam logic [6:0] O_OVER_W2 = 7'b0_00_0_1_10;
  localparam logic [6:0] O_OVER_W1 = 7'b0_00_0_1_01;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_start = 1'b0;
  logic btn_pause = 1'b0;
  logic btn_p1 = 1'b0;
  logic btn_p2 = 1'b0;
  logic timeout1 = 1'b0;
  logic timeout2 = 1'b0;
  logic       enable;
  logic [1:0] player;
  logic       paused;
  logic       game_over;
  logic [1:0] winner;

  game_fsm #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .btn_p1    (btn_p1),
    .btn_p2    (btn_p2),
    .timeout1  (timeout1),
    .timeout2  (timeout2),
    .enable    (enable),
    .player    (player),
    .paused    (paused),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int cyc, input logic [6:0] v);
    exp_t e;
    e.cyc = cyc;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      BTN_START: btn_start = v;
      BTN_PAUSE: btn_pause = v;
      BTN_P1:    btn_p1    = v;
      default:   btn_p2    = v;
    endcase
  endtask

  // Hold, release, then let the release debounce fully before the next press.
  task automatic press(input int which, input int hold);
    set_btn(which, 1'b1);
    tick(hold);
    set_btn(which, 1'b0);
    tick(12);
  endtask

  task automatic press_expect(input int which, input logic [6:0] v);
    expect_at(cycle_cnt + LAT, v);
    press(which, 10);
  endtask

  // Monitor: every output change must match the head of the queue, on time.
  initial begin
    logic [6:0] prev;
    logic [6:0] cur;
    logic       first;
    exp_t       e;
    prev  = '0;
    first = 1'b1;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      cur = {enable, player, paused, game_over, winner};
      while (exp_q.size() > 0 && exp_q[0].cyc < cycle_cnt) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_change: wanted %b at edge %0d, outputs still %b at edge %0d",
                 e.val, e.cyc, cur, cycle_cnt);
      end
      if (first || cur !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: outputs became %b at edge %0d, required no change from %b",
                   cur, cycle_cnt, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.val !== cur || e.cyc != cycle_cnt) begin
            n_fail++;
            $display("FAIL output_change: got %b at edge %0d, required %b at edge %0d",
                     cur, cycle_cnt, e.val, e.cyc);
          end else begin
            $display("check edge %0d: outputs %b as expected", cycle_cnt, cur);
          end
        end
        prev  = cur;
        first = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    expect_at(0, O_IDLE);
    #2 reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);

    press_expect(BTN_START, O_P1);
    press(BTN_P1, 3);                    // glitch shorter than the window
    press_expect(BTN_P1, O_P2);
    press_expect(BTN_P2, O_P1);
    press(BTN_P2, 10);                   // wrong player's button
    press_expect(BTN_P1, O_P2);

    press_expect(BTN_PAUSE, O_PAUSE2);
    press(BTN_P1, 10);
    press(BTN_P2, 10);
    press(BTN_START, 10);
    press_expect(BTN_PAUSE, O_P2);
    press_expect(BTN_P2, O_P1);

    // timeout1 in the same cycle the p1 press pulse is high
    expect_at(cycle_cnt + LAT, O_OVER_W2);
    btn_p1 = 1'b1;
    tick(LAT - 1);
    timeout1 = 1'b1;
    tick(1);
    timeout1 = 1'b0;
    tick(2);
    btn_p1 = 1'b0;
    tick(12);
    press_expect(BTN_START, O_IDLE);

    press_expect(BTN_START, O_P1);
    press_expect(BTN_P1, O_P2);
    // timeout2 in the same cycle the pause press pulse is high
    expect_at(cycle_cnt + LAT, O_OVER_W1);
    btn_pause = 1'b1;
    tick(LAT - 1);
    timeout2 = 1'b1;
    tick(1);
    timeout2 = 1'b0;
    tick(2);
    btn_pause = 1'b0;
    tick(12);
    press_expect(BTN_START, O_IDLE);

    press_expect(BTN_START, O_P1);
    press_expect(BTN_PAUSE, O_PAUSE1);
    timeout1 = 1'b1;                     // ignored while paused
    tick(2);
    timeout1 = 1'b0;
    tick(2);

    // Reset mid-debounce, between clock edges; start stays held through it.
    btn_start = 1'b1;
    tick(3);
    #7;
    expect_at(cycle_cnt, O_IDLE);
    reset = 1'b1;
    @(negedge clk);
    expect_at(cycle_cnt + LAT, O_P1);
    reset = 1'b0;
    tick(10);
    btn_start = 1'b0;
    tick(20);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: %0d left in queue, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_fsm.md
# game_fsm

Game-sequencing controller for the chess clock. Sits directly upstream of the timers control stage. Converts the raw board buttons (start, pause, player 1 and player 2 turn buttons) plus the timeout flags from the two countdown timers into the `enable` / `player` pair that selects which player timer runs. Also reports pause, game-over and winner status to the display logic.

## Interface

- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- `CNT_W`, default 20: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk` input 1: system clock (100 MHz on Nexys 4).
- `reset` input 1: asynchronous, active-high reset.
- `btn_start` input 1: raw start / new-game button, asynchronous, bouncy.
- `btn_pause` input 1: raw pause/resume button, asynchronous, bouncy.
- `btn_p1` input 1: raw player-1 end-of-turn button, asynchronous, bouncy.
- `btn_p2` input 1: raw player-2 end-of-turn button, asynchronous, bouncy.
- `timeout1` input 1: player-1 timer reached zero; synchronous to `clk`, level.
- `timeout2` input 1: player-2 timer reached zero; synchronous to `clk`, level.
- `enable` output 1: a player timer must run.
- `player` output 2: 01 = player 1 running, 10 = player 2 running, 00 = none.
- `paused` output 1: high in PAUSED.
- `game_over` output 1: high in OVER.
- `winner` output 2: 01 = player 1 won, 10 = player 2 won, 00 = undecided.

## Operation

- Button conditioning, per button:
  - 2-FF synchronizer.
  - Debounce counter clears whenever the synchronized level equals the debounced level. Otherwise it increments; at DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - Registered rising-edge detector on the debounced level gives a one-cycle press pulse. Releases produce nothing.
- `timeout1` and `timeout2` are used unconditioned.
- States: IDLE, RUN_P1, RUN_P2, PAUSED, OVER. PAUSED keeps a 1-bit `resume_p2` register.
- Transitions, evaluated on the press pulses and timeouts of the current cycle:
  - IDLE: start -> RUN_P1. All other inputs are ignored.
  - RUN_P1:
    - timeout1 -> OVER, winner=10.
    - else pause -> PAUSED, resume_p2=0.
    - else p1 -> RUN_P2.
    - p2 and start are ignored.
  - RUN_P2:
    - timeout2 -> OVER, winner=01.
    - else pause -> PAUSED, resume_p2=1.
    - else p2 -> RUN_P1.
    - p1 and start are ignored.
  - PAUSED: pause -> RUN_P2 if resume_p2, else RUN_P1. Start, p1, p2 and timeouts are ignored.
  - OVER: start -> IDLE and winner cleared. Everything else is ignored; winner holds.
- Priority for simultaneous events in one cycle: timeout > pause > turn button.
- Outputs are registered and decoded from the state:
  - IDLE: enable=0, player=00.
  - RUN_P1: enable=1, player=01.
  - RUN_P2: enable=1, player=10.
  - PAUSED: enable=0, player=01 or 10 according to resume_p2.
  - OVER: enable=0, player=00.
- `player` is never 11.

## Timing

- Reset (asynchronous, any time including mid-game or mid-debounce):
  - State goes to IDLE.
  - All synchronizer, debounced and edge registers go to 0, and all counters clear.
  - Outputs: enable=0, player=00, paused=0, game_over=0, winner=00, resume_p2=0.
- Button latency: the raw level held high from clk edge 0 produces its output change at edge DEBOUNCE_CYCLES+4.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- A button held down produces exactly one pulse.
- Timeout latency: a timeout high at edge n changes the outputs at edge n+1.
- At most one state transition per cycle.

## Test plan

DEBOUNCE_CYCLES=4 for all cases.

- Reset, then press start held for 10 cycles -> enable=1, player=01 at edge 8 after the press; exactly one transition.
- In RUN_P1, a 3-cycle btn_p1 glitch -> no change. Then a clean btn_p1 press -> player=10. Then btn_p2 -> player=01. A btn_p2 press while in RUN_P1 -> ignored.
- In RUN_P2, press pause -> enable=0, player=10, paused=1. btn_p1/btn_p2 presses -> ignored. Pause again -> enable=1, player=10, paused=0.
- In RUN_P1, assert timeout1 in the same cycle the p1 press pulse fires -> OVER, game_over=1, winner=10, enable=0, player=00. Start press -> IDLE, winner=00.
- In RUN_P2, pause pulse and timeout2 in the same cycle -> OVER, winner=01, paused=0.
- Assert reset mid-debounce while in PAUSED -> all outputs 0 immediately, without waiting for a clock edge. After release, a press needs the full DEBOUNCE_CYCLES+4 cycles again.
